// File: rtl/if_id_skid.sv
// IF/ID ready/valid stage with a 2-entry skid buffer and synchronous flush.
// Optional IF_ID_STALL_CNT_EN adds a saturating decode-stall counter port.
module if_id_skid #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_pc,
    input  logic [n-1:0] in_instr,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_pc,
    output logic [n-1:0] out_instr
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] TWO   = 2'b11;

    logic         main_v;
    logic         skid_v;
    logic [n-1:0] main_pc;
    logic [n-1:0] main_instr;
    logic [n-1:0] skid_pc;
    logic [n-1:0] skid_instr;
    logic         acc;
    logic         take;

    // in_ready comes from flops and reset only, never from out_ready
    assign in_ready  = !skid_v && !reset;
    assign out_valid = main_v;
    assign out_pc    = main_pc;
    assign out_instr = main_instr;
    assign acc       = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            main_pc    <= '0;
            main_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            case ({main_v, skid_v})
                EMPTY: begin
                    if (acc) begin
                        main_v     <= 1'b1;
                        main_pc    <= in_pc;
                        main_instr <= in_instr;
                    end
                end
                ONE: begin
                    if (acc && !take) begin
                        skid_v     <= 1'b1;
                        skid_pc    <= in_pc;
                        skid_instr <= in_instr;
                    end else if (acc && take) begin
                        main_pc    <= in_pc;
                        main_instr <= in_instr;
                    end else if (take) begin
                        main_v <= 1'b0;
                    end
                end
                TWO: begin
                    if (take) begin
                        skid_v     <= 1'b0;
                        main_pc    <= skid_pc;
                        main_instr <= skid_instr;
                    end
                end
                default: begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    // flush deliberately leaves the count alone
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Scoreboard bench for if_id_skid: directed test-plan phases, then random traffic.
// The reference is a plain FIFO of at most two words plus the last delivered word.
module tb_if_id_skid;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] mcnt = '0;
`endif

    int          total = 0;
    int          bad = 0;
    bit          armed = 1'b0;
    logic [63:0] q[$];
    logic [63:0] last = '0;
    logic [31:0] npc = '0;

    if_id_skid #(.n(32)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the pre-edge outputs with the model, pops on delivery
    always @(posedge clk) begin
        if (armed) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(!reset && q.size() < 2));
            if (q.size() > 0)
                chk("out_word", {out_pc, out_instr}, q[0]);
            else
                chk("idle_word", {out_pc, out_instr}, last);
`ifdef IF_ID_STALL_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
            if (reset) mcnt = '0;
            else if (q.size() > 0 && !out_ready && mcnt != 32'hFFFF_FFFF) mcnt++;
`endif
            if (q.size() > 0 && out_ready && !reset && !flush)
                last = q.pop_front();
        end
    end

    // Driver: applies one cycle of inputs, then updates the expected queue
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic rs);
        bit acc;
        @(negedge clk);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        acc = v && !rs && (q.size() < 2);
        @(posedge clk);
        #1;
        if (rs || fl) begin
            q.delete();
            last = '0;
        end else if (acc) begin
            q.push_back({pc, ins});
        end
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        armed = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        // stream at full rate
        for (int i = 0; i < 4; i++)
            step(1, 32'(i * 4), 32'h2008_0005 + 32'(i), 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // backpressure fill to TWO, then drain
        step(1, 32'h10, 32'hAAAA_0010, 0, 0, 0);
        step(1, 32'h14, 32'hAAAA_0014, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // flush with a full buffer and a concurrent offer
        step(1, 32'h20, 32'hBBBB_0020, 0, 0, 0);
        step(1, 32'h24, 32'hBBBB_0024, 0, 0, 0);
        step(1, 32'h28, 32'hBBBB_0028, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // accept and take in the same cycle
        step(1, 32'h30, 32'hCCCC_0030, 1, 0, 0);
        step(1, 32'h34, 32'hCCCC_0034, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // reset while full
        step(1, 32'h38, 32'hDDDD_0038, 0, 0, 0);
        step(1, 32'h3c, 32'hDDDD_003c, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h40, 32'hDDDD_0040, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // five stalled cycles, flush, then reset
        step(1, 32'h44, 32'hEEEE_0044, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        // random traffic
        npc = 32'h100;
        for (int i = 0; i < 600; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            step(v, npc, $urandom, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 79) == 0));
            if (v) npc = npc + 32'd4;
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
